regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the RISC-V core. Successor to the single-write, two-read register block.
- Adds:
  - configurable XLEN, register count and read/write port counts
  - hardwired x0
  - optional write-to-read bypass
  - optional registered read stage gated by rd_en
  - per-register busy scoreboard for pipeline hazard detection
- Sits between decode (read/alloc) and writeback (write).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >=2)
NRD, 2, number of read ports
NWR, 1, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to reads of the same address
REG_READ, 0, 0 = combinational read; 1 = registered read, one-cycle latency

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
wd_en  in  NWR  per-port write enable
wd_sel  in  NWR x log2(NREGS)  per-port write address
wd_data  in  NWR x XLEN  per-port write data
rd_en  in  1  read-stage enable; used only when REG_READ=1
rs_add  in  NRD x log2(NREGS)  per-port read address
rs_data  out  NRD x XLEN  per-port read data
alloc_en  in  1  mark destination register busy (issue)
alloc_sel  in  log2(NREGS)  register to mark busy
rs_busy  out  NRD  busy flag of the register at rs_add[i], combinational

Behaviour:
- Reset, taking effect at the clock edge where rst=1:
  - all registers 0, all busy bits 0, registered rs_data 0
  - rst dominates any write or alloc in the same cycle
- x0 (address 0):
  - writes are ignored
  - alloc is ignored
  - reads always return 0
  - rs_busy is always 0
- Write:
  - on the clock edge, reg[wd_sel[j]] <= wd_data[j] for each j with wd_en[j]=1
  - multiple ports writing the same address in one cycle: the highest port index wins
- Read, REG_READ=0:
  - rs_data[i] = reg[rs_add[i]], combinational
  - BYPASS=1 and a write to the same non-zero address is enabled this cycle: return the winning wd_data
  - BYPASS=0: return the old value; the new value is visible the next cycle
- Read, REG_READ=1:
  - rs_data[i] is registered, updated at the edge when rd_en=1, held when rd_en=0
  - the captured value follows the same bypass rule applied to the cycle of capture
  - latency is one cycle from rs_add/rd_en to rs_data
- Scoreboard, busy[r] for r != 0:
  - set at the edge where alloc_en=1 and alloc_sel=r
  - cleared at the edge where any enabled write port targets r
  - alloc and write to the same r in the same cycle: busy ends at 1 (the new producer wins); the write data is still committed
  - allocating an already-busy register leaves it busy, with no error
- rs_busy[i] = busy[rs_add[i]], combinational.
  - With BYPASS=1, rs_busy[i] is forced to 0 when a write to rs_add[i] is enabled this cycle and no alloc to the same register occurs.
- Out-of-range addresses cannot occur because NREGS is a power of 2.
- Mid-run reset: all state is cleared in one cycle, with no drain.

Decomposition:
- Package regfile_pkg:
  - defaults for XLEN and NREGS
  - localparam AW = $clog2(NREGS)
  - typedefs reg_addr_t and xlen_t
- Sub-module regfile_wr_arb:
  - combinational write-port priority resolution for one address
  - produces a hit flag and the winning data
  - one instance per read port for bypass, plus reuse in the storage write loop
- Storage, scoreboard and read stage are implemented in regfile_mp.

Test Plan:
- Reset with every register preloaded -> after one edge with rst=1, reading x1..x31 returns 0 and rs_busy returns 0.
- Write 43 to x3, then read rs_add[0]=3 -> rs_data[0]=43. Write 0xDEAD to x0 -> a read of x0 returns 0.
- BYPASS=1: write x5=7 while reading x5 in the same cycle, old value 1 -> rs_data=7. With BYPASS=0 -> rs_data=1, then 7 on the next cycle.
- NWR=2: both ports write x9 in the same cycle, with data 11 on port 0 and 22 on port 1 -> x9=22.
- Scoreboard:
  - alloc x7 -> rs_busy=1
  - write x7 -> busy=0
  - alloc x7 and write x7 in the same cycle -> busy stays 1 and the data is committed
  - alloc x0 -> rs_busy stays 0
- REG_READ=1: write x4=99, then a read with rd_en=1 -> rs_data=99 one cycle later. With rd_en=0 -> the previous rs_data is held. rst=1 asserted mid-sequence -> rs_data=0 at the next edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and types for the multi-port integer register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW        = $clog2(NREGS_DEF);

    typedef logic [AW-1:0]       reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port priority resolution for a single register address.
// The highest-indexed enabled port that targets addr_i supplies data_o.
module regfile_wr_arb #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NWR  = 1
) (
    input  logic [NWR-1:0]           wd_en,
    input  logic [NWR-1:0][AW-1:0]   wd_sel,
    input  logic [NWR-1:0][XLEN-1:0] wd_data,
    input  logic [AW-1:0]            addr_i,
    output logic                     hit_o,
    output logic [XLEN-1:0]          data_o
);

    // Ascending scan: a later match overrides an earlier one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wd_en[j] && (wd_sel[j] == addr_i)) begin
                hit_o  = 1'b1;
                data_o = wd_data[j];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired x0, optional write bypass,
// optional registered read stage and a per-register busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREGS    = NREGS_DEF,
    parameter  int NRD      = 2,
    parameter  int NWR      = 1,
    parameter  int BYPASS   = 1,
    parameter  int REG_READ = 0,
    localparam int RAW      = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NWR-1:0]           wd_en,
    input  logic [NWR-1:0][RAW-1:0]  wd_sel,
    input  logic [NWR-1:0][XLEN-1:0] wd_data,
    input  logic                     rd_en,
    input  logic [NRD-1:0][RAW-1:0]  rs_add,
    output logic [NRD-1:0][XLEN-1:0] rs_data,
    input  logic                     alloc_en,
    input  logic [RAW-1:0]           alloc_sel,
    output logic [NRD-1:0]           rs_busy
);

    logic [XLEN-1:0]              regs_q [NREGS];
    logic [XLEN-1:0]              regs_d [NREGS];
    logic [NREGS-1:0]             busy_q;
    logic [NREGS-1:0]             busy_d;

    logic [NREGS-1:1]             wr_hit;
    logic [NREGS-1:1][XLEN-1:0]   wr_dat;

    logic [NRD-1:0]               rd_hit;
    logic [NRD-1:0][XLEN-1:0]     rd_wdat;
    logic [NRD-1:0][XLEN-1:0]     rd_val;
    logic [NRD-1:0]               busy_val;

    // One arbiter per architectural register (x0 excluded) resolves its write.
    for (genvar r = 1; r < NREGS; r++) begin : g_wr
        regfile_wr_arb #(.XLEN(XLEN), .AW(RAW), .NWR(NWR)) u_arb (
            .wd_en   (wd_en),
            .wd_sel  (wd_sel),
            .wd_data (wd_data),
            .addr_i  (RAW'(r)),
            .hit_o   (wr_hit[r]),
            .data_o  (wr_dat[r])
        );
    end

    // One arbiter per read port supplies same-cycle forwarded write data.
    if (BYPASS != 0) begin : g_byp
        for (genvar i = 0; i < NRD; i++) begin : g_port
            regfile_wr_arb #(.XLEN(XLEN), .AW(RAW), .NWR(NWR)) u_arb (
                .wd_en   (wd_en),
                .wd_sel  (wd_sel),
                .wd_data (wd_data),
                .addr_i  (rs_add[i]),
                .hit_o   (rd_hit[i]),
                .data_o  (rd_wdat[i])
            );
        end
    end else begin : g_nobyp
        assign rd_hit  = '0;
        assign rd_wdat = '0;
    end

    // Next-state of storage and scoreboard; alloc is applied after the write
    // clear so a same-cycle alloc leaves the register busy for the new producer.
    always_comb begin
        regs_d    = regs_q;
        busy_d    = busy_q;
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (wr_hit[r]) begin
                regs_d[r] = wr_dat[r];
                busy_d[r] = 1'b0;
            end
            if (alloc_en && (alloc_sel == RAW'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    // Storage and scoreboard registers; reset overrides any write or alloc.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Per-port read value and busy flag, with x0 forced to zero and not busy.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_val[i]   = regs_q[rs_add[i]];
            busy_val[i] = busy_q[rs_add[i]];
            if (rs_add[i] == '0) begin
                rd_val[i]   = '0;
                busy_val[i] = 1'b0;
            end else if (rd_hit[i]) begin
                rd_val[i] = rd_wdat[i];
                if (!(alloc_en && (alloc_sel == rs_add[i]))) begin
                    busy_val[i] = 1'b0;
                end
            end
        end
    end

    assign rs_busy = busy_val;

    if (REG_READ != 0) begin : g_rreg
        logic [NRD-1:0][XLEN-1:0] rs_data_q;

        // Read stage captures on rd_en and holds otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                rs_data_q <= '0;
            end else if (rd_en) begin
                rs_data_q <= rd_val;
            end
        end

        assign rs_data = rs_data_q;
    end else begin : g_rcomb
        logic unused_rd_en;
        assign unused_rd_en = rd_en;
        assign rs_data      = rd_val;
    end

endmodule
